gray_ptr_sync: RTL
==================

GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

Interface
REQ-001 Parameter PTR_W, default 5: width of the Gray-coded pointer, wrap bit included; legal range 2..16.
REQ-002 Parameter STAGES, default 2: synchronizer flop count; legal range 2..4.
REQ-003 Parameter ERR_CNT_W, default 8: width of the error counter; legal range 1..16.
REQ-004 Port clk, input, 1: destination-domain clock; all flops use the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port gray_in, input, PTR_W: Gray-coded pointer from the foreign clock domain.
REQ-007 Port err_clr, input, 1: synchronous clear of gray_err and err_cnt.
REQ-008 Port ptr_gray_out, output, PTR_W: synchronized Gray pointer.
REQ-009 Port ptr_bin_out, output, PTR_W: binary equivalent of ptr_gray_out.
REQ-010 Port ptr_chg, output, 1: single-cycle pulse when the synchronized pointer changes.
REQ-011 Port gray_err, output, 1: sticky flag for a multi-bit change.
REQ-012 Port err_cnt, output, ERR_CNT_W: saturating count of multi-bit changes.

Function
REQ-013 gray_in SHALL pass through a chain of STAGES flops s[0]..s[STAGES-1], with no combinational logic in front of s[0].
REQ-014 One output register stage SHALL capture s[STAGES-1] every cycle into ptr_gray_out, into ptr_bin_out (Gray-to-binary: b[MSB]=g[MSB], b[i]=b[i+1] XOR g[i]), and into ptr_chg.
REQ-015 ptr_chg SHALL be registered as (s[STAGES-1] != ptr_gray_out), sampled before the update.
REQ-016 Latency: a gray_in value stable before clock edge k SHALL appear on ptr_gray_out, ptr_bin_out and ptr_chg after edge k+STAGES; all three outputs SHALL be cycle-aligned.
REQ-017 Multi-bit detect: an error event SHALL occur when popcount(s[STAGES-1] XOR ptr_gray_out) > 1, evaluated in the same cycle as ptr_chg.
REQ-018 On an error event, gray_err SHALL be set on the next edge and SHALL remain set until err_clr or reset.
REQ-019 On an error event, err_cnt SHALL increment by 1 and SHALL saturate at all-ones, never wrapping.
REQ-020 With err_clr=1 and no error event, gray_err SHALL go to 0 and err_cnt SHALL go to 0 on the next edge.
REQ-021 With err_clr=1 and an error event in the same cycle, the error SHALL win: gray_err SHALL be 1 and err_cnt SHALL be 1.
REQ-022 A pointer wrap (for example Gray 10000 -> 00000, binary 31 -> 0) is a single-bit change and SHALL NOT raise an error event.
REQ-023 A multi-bit change SHALL still update ptr_gray_out, ptr_bin_out and ptr_chg normally; no value is filtered or held.

Reset
REQ-024 While reset is high, all sync flops, ptr_gray_out, ptr_bin_out, ptr_chg, gray_err and err_cnt SHALL be 0, asynchronously, and SHALL remain 0 for the whole assertion.
REQ-025 Reset asserted mid-operation SHALL discard in-flight values; after release, outputs SHALL track gray_in with the latency of REQ-016, and the first non-zero value SHALL produce one ptr_chg pulse.

Configuration
REQ-026 Macro GRAY_PTR_SYNC_CHECK_EN: when defined, the multi-bit detect, gray_err and err_cnt logic SHALL be compiled in as specified above.
REQ-027 When GRAY_PTR_SYNC_CHECK_EN is undefined, gray_err and err_cnt SHALL be tied to 0, err_clr SHALL be ignored, no detect logic SHALL be synthesized, and all ports SHALL be unchanged.

Verification (PTR_W=5, STAGES=2, ERR_CNT_W=8, macro defined)
REQ-028 Reset held, then released with gray_in=00000 -> all outputs 0 and ptr_chg never pulses.
REQ-029 gray_in 00000 -> 00001 before edge k -> after edge k+2: ptr_gray_out=00001, ptr_bin_out=1, ptr_chg=1 for exactly one cycle; gray_err stays 0.
REQ-030 Full Gray count of 32 steps, one step per 4 cycles, including wrap 10000 -> 00000 -> ptr_bin_out steps 0..31 then 0; 32 ptr_chg pulses; err_cnt stays 0.
REQ-031 Jump 00000 -> 00011 -> gray_err=1, err_cnt=1, ptr_bin_out=2; a second jump together with err_clr=1 in the detect cycle -> gray_err=1, err_cnt=1.
REQ-032 300 injected multi-bit jumps -> err_cnt=255 (saturated); then err_clr pulse -> err_cnt=0, gray_err=0.
REQ-033 Reset asserted with value 01100 in flight -> outputs 0 immediately; after release with gray_in=01100 -> ptr_bin_out=8 after 2 edges, one ptr_chg pulse, gray_err=0.

Source files
------------

// File: rtl/gray_ptr_sync.sv
// Gray-coded pointer synchronizer with a binary view, a change pulse and a multi-bit change detector.
// Defining GRAY_PTR_SYNC_CHECK_EN compiles in the detector (gray_err, err_cnt); otherwise both outputs are tied to 0.
module gray_ptr_sync #(
    parameter int PTR_W     = 5,
    parameter int STAGES    = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PTR_W-1:0]     gray_in,
    input  logic                 err_clr,
    output logic [PTR_W-1:0]     ptr_gray_out,
    output logic [PTR_W-1:0]     ptr_bin_out,
    output logic                 ptr_chg,
    output logic                 gray_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [PTR_W-1:0] sync_reg [STAGES];
    logic [PTR_W-1:0] sync_last;
    logic [PTR_W-1:0] bin_next;
    logic [PTR_W-1:0] ptr_gray_reg;
    logic [PTR_W-1:0] ptr_bin_reg;
    logic             ptr_chg_reg;
    logic             ptr_chg_next;

    // The first stage samples gray_in directly, with no logic in front of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= gray_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign sync_last = sync_reg[STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < PTR_W; gi++) begin : g_g2b
            assign bin_next[gi] = ^sync_last[PTR_W-1:gi];
        end
    endgenerate

    assign ptr_chg_next = (sync_last != ptr_gray_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_gray_reg <= '0;
            ptr_bin_reg  <= '0;
            ptr_chg_reg  <= 1'b0;
        end else begin
            ptr_gray_reg <= sync_last;
            ptr_bin_reg  <= bin_next;
            ptr_chg_reg  <= ptr_chg_next;
        end
    end

    assign ptr_gray_out = ptr_gray_reg;
    assign ptr_bin_out  = ptr_bin_reg;
    assign ptr_chg      = ptr_chg_reg;

`ifdef GRAY_PTR_SYNC_CHECK_EN
    logic [PTR_W-1:0]     diff;
    logic                 multi_bit;
    logic                 gray_err_reg;
    logic                 gray_err_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg;
    logic [ERR_CNT_W-1:0] err_cnt_next;

    // More than one bit set iff clearing the lowest set bit leaves something behind.
    assign diff      = sync_last ^ ptr_gray_reg;
    assign multi_bit = |(diff & (diff - PTR_W'(1)));

    always_comb begin
        gray_err_next = gray_err_reg;
        err_cnt_next  = err_cnt_reg;
        if (multi_bit) begin
            gray_err_next = 1'b1;
            if (err_clr) begin
                err_cnt_next = ERR_CNT_W'(1);
            end else if (!(&err_cnt_reg)) begin
                err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            gray_err_next = 1'b0;
            err_cnt_next  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_err_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            gray_err_reg <= gray_err_next;
            err_cnt_reg  <= err_cnt_next;
        end
    end

    assign gray_err = gray_err_reg;
    assign err_cnt  = err_cnt_reg;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign gray_err       = 1'b0;
    assign err_cnt        = '0;
`endif

endmodule
